// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: decoder-side control and HI/LO result bundle for the
// iterative multiply/divide unit. The decoder (master) drives the mult/div/
// mflo/mfhi controls and operands; the unit (slave) returns result, HI, LO,
// busy and stall.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult;
    logic             div;
    logic             mflo;
    logic             mfhi;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;

    modport master (
        output mult, div, mflo, mfhi, srca, srcb,
        input  result, hi, lo, busy, stall
    );

    modport slave (
        input  mult, div, mflo, mfhi, srca, srcb,
        output result, hi, lo, busy, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI/LO.
// A start edge captures the operands, then WIDTH iterations run one per clock;
// HI/LO are written on the last iteration edge. mflo/mfhi reads are served
// combinationally and stall while an operation is in flight.
// Optional feature: define MULDIV_SIGNED_EN for two's-complement operands
// (magnitude datapath with sign correction at completion). Without it the
// unit is purely unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,   // asynchronous, active low
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CW-1:0]      count_reg;
    // Shared working register: multiply keeps {carry, partial high, multiplier},
    // divide keeps {remainder (WIDTH+1), dividend/quotient (WIDTH)}.
    logic [2*WIDTH:0]   acc_reg;
    logic [WIDTH-1:0]   opb_reg;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               start_mul;
    logic               start_div;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH:0]   div_step;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH-1:0]   hi_final;
    logic [WIDTH-1:0]   lo_final;

`ifdef MULDIV_SIGNED_EN
    logic               signa_reg;
    logic               signb_reg;
    logic [2*WIDTH-1:0] prod_neg;

    assign mag_a = bus.srca[WIDTH-1] ? (~bus.srca + 1'b1) : bus.srca;
    assign mag_b = bus.srcb[WIDTH-1] ? (~bus.srcb + 1'b1) : bus.srcb;
`else
    assign mag_a = bus.srca;
    assign mag_b = bus.srcb;
`endif

    assign last_iter = (count_reg == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a start is only accepted from IDLE, mult has priority
    always_comb begin
        state_next = state_reg;
        start_mul  = 1'b0;
        start_div  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.mult) begin
                    state_next = MUL;
                    start_mul  = 1'b1;
                end else if (bus.div) begin
                    state_next = DIV;
                    start_div  = 1'b1;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration of each algorithm computed from the current working register
    always_comb begin
        // Shift-add: add multiplicand into the upper WIDTH+1 bits when the
        // multiplier LSB is set, then shift the whole accumulator right.
        mul_sum  = acc_reg[2*WIDTH:WIDTH] + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        mul_step = {1'b0, mul_sum, acc_reg[WIDTH-1:1]};
        // Restoring divide: shift next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb_reg};
        if (div_trial[WIDTH+1]) begin
            div_step = {div_shift, acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_trial[WIDTH:0], acc_reg[WIDTH-2:0], 1'b1};
        end
        acc_step = (state_reg == DIV) ? div_step : mul_step;
    end

    // Final HI/LO values from the last iteration, with sign correction if enabled
    always_comb begin
        hi_final = acc_step[2*WIDTH-1:WIDTH];
        lo_final = acc_step[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        prod_neg = ~acc_step[2*WIDTH-1:0] + 1'b1;
        if (state_reg == MUL) begin
            if (signa_reg ^ signb_reg) begin
                hi_final = prod_neg[2*WIDTH-1:WIDTH];
                lo_final = prod_neg[WIDTH-1:0];
            end
        end else begin
            // Remainder takes the dividend's sign; a zero divisor still yields
            // an all-ones quotient and hands the dividend back in HI.
            if (signa_reg) begin
                hi_final = ~acc_step[2*WIDTH-1:WIDTH] + 1'b1;
            end
            if (opb_reg == '0) begin
                lo_final = '1;
            end else if (signa_reg ^ signb_reg) begin
                lo_final = ~acc_step[WIDTH-1:0] + 1'b1;
            end
        end
`endif
    end

    // Datapath: operand capture on start, iterate while busy, commit HI/LO on the last edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            acc_reg   <= '0;
            opb_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
`ifdef MULDIV_SIGNED_EN
            signa_reg <= 1'b0;
            signb_reg <= 1'b0;
`endif
        end else if (start_mul || start_div) begin
            count_reg <= '0;
            acc_reg   <= {{(WIDTH+1){1'b0}}, (start_mul ? mag_b : mag_a)};
            opb_reg   <= start_mul ? mag_a : mag_b;
`ifdef MULDIV_SIGNED_EN
            signa_reg <= bus.srca[WIDTH-1];
            signb_reg <= bus.srcb[WIDTH-1];
`endif
        end else if (state_reg != IDLE) begin
            acc_reg   <= acc_step;
            count_reg <= count_reg + CW'(1);
            if (last_iter) begin
                hi_reg <= hi_final;
                lo_reg <= lo_final;
            end
        end
    end

    assign bus.hi     = hi_reg;
    assign bus.lo     = lo_reg;
    assign bus.result = bus.mfhi ? hi_reg : lo_reg;
    assign bus.busy   = (state_reg != IDLE);
    assign bus.stall  = (bus.mult | bus.div | bus.mflo | bus.mfhi) & bus.busy;

endmodule
